// File: rtl/debounce_pulse.sv
// debounce_pulse
// Conditions a raw active-low push-button into a debounced "pressed" level
// and a one-cycle pulse for each accepted press. When repeat_en is high and
// the button stays held, the block also emits auto-repeat pulses. The pulse
// output drives the enable input of the downstream modulo counter.
module debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_n,
    input  logic repeat_en,
    output logic level,
    output logic pulse
);

    // One counter is shared by every timed state. It only has to reach the
    // largest limit minus one, and each limit compare clears it, so it
    // cannot wrap.
    localparam int MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_DEB_PRESS   = 3'd1;
    localparam logic [2:0] ST_PRESSED     = 3'd2;
    localparam logic [2:0] ST_REPEAT      = 3'd3;
    localparam logic [2:0] ST_DEB_RELEASE = 3'd4;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic          btn_s;

    // Pressed is 1 after the synchroniser.
    assign btn_s = ~sync2_q;

    // Two-stage synchroniser on the asynchronous button, with nothing between the stages.
    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
    end

    // Next-state logic for the debounce, hold and repeat sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_DEB_PRESS;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_DEB_PRESS: begin
                if (!btn_s) begin
                    // A bounce: give up quietly and wait for the next edge.
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!btn_s) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = CNT_ZERO;
                end else if (!repeat_en) begin
                    // With repeat disabled, keep the hold timer at zero.
                    cnt_d = CNT_ZERO;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_REPEAT;
                    cnt_d   = CNT_ZERO;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!btn_s) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = CNT_ZERO;
                end else if (!repeat_en) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d   = CNT_ZERO;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DEB_RELEASE: begin
                if (btn_s) begin
                    // A release bounce: the button is still held, and the
                    // hold timing starts again from zero.
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                // An unreachable encoding goes back to a known released state.
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                level_d = 1'b0;
            end
        endcase
    end

    // State, counter, synchroniser and output registers, with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// tb_debounce_pulse
// Bench for debounce_pulse with DEBOUNCE=4, HOLD=10 and REPEAT=5.
// The reference model tracks run lengths of the synchronised button and a
// count of enabled hold cycles. Directed scenarios then check the exact
// pulse timing with fixed numbers.
module tb_debounce_pulse;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 5;

    logic clock = 1'b0;
    logic reset_n;
    logic btn_n;
    logic repeat_en;
    logic level;
    logic pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    logic m_level, m_pulse;
    logic m_d1, m_d2;      // btn_n as sampled one and two edges ago
    int   run1, run0;      // consecutive pressed / released samples seen
    int   n_held;          // enabled hold edges since the last restart
    logic rel_pending;     // a release is being debounced

    int cyc_idx;
    int pulse_idx[$];

    debounce_pulse #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn_n    (btn_n),
        .repeat_en(repeat_en),
        .level    (level),
        .pulse    (pulse)
    );

    always #5 clock = ~clock;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pulse_at(input string tag, input int k, input int exp);
        int obs;
        if (k < pulse_idx.size()) obs = pulse_idx[k];
        else obs = -1;
        check_int(tag, obs, exp);
    endtask

    task automatic model_reset();
        m_level     = 1'b0;
        m_pulse     = 1'b0;
        m_d1        = 1'b1;
        m_d2        = 1'b1;
        run1        = 0;
        run0        = 0;
        n_held      = 0;
        rel_pending = 1'b0;
    endtask

    // One rising edge of the model. The FSM sees btn_n as it was sampled two edges earlier.
    task automatic model_edge();
        logic s;
        s    = ~m_d2;
        m_d2 = m_d1;
        m_d1 = btn_n;
        if (s) begin run1++; run0 = 0; end
        else   begin run0++; run1 = 0; end
        m_pulse = 1'b0;
        if (!m_level) begin
            // Accept a press after D+1 consecutive pressed samples.
            if (run1 == D + 1) begin
                m_level     = 1'b1;
                m_pulse     = 1'b1;
                n_held      = 0;
                rel_pending = 1'b0;
            end
        end else if (!s) begin
            rel_pending = 1'b1;
            if (run0 == D + 1) m_level = 1'b0;
        end else if (rel_pending) begin
            rel_pending = 1'b0;
            n_held      = 0;
        end else if (!repeat_en) begin
            n_held = 0;
        end else begin
            n_held++;
            if (n_held == H || (n_held > H && ((n_held - H) % R) == 0)) m_pulse = 1'b1;
        end
    endtask

    // Advance one clock, update the model and compare on the falling edge.
    task automatic cycle();
        @(posedge clock);
        if (reset_n) model_edge();
        @(negedge clock);
        check_bit("level", level, m_level);
        check_bit("pulse", pulse, m_pulse);
        if (pulse === 1'b1) pulse_idx.push_back(cyc_idx);
        cyc_idx++;
    endtask

    task automatic hold(input logic b, input logic rep, input int ncyc);
        btn_n     = b;
        repeat_en = rep;
        for (int i = 0; i < ncyc; i++) cycle();
    endtask

    task automatic new_window();
        pulse_idx.delete();
        cyc_idx = 0;
    endtask

    initial begin
        reset_n   = 1'b1;
        btn_n     = 1'b1;
        repeat_en = 1'b0;
        model_reset();
        cyc_idx = 0;
        #2 reset_n = 1'b0;
        hold(1'b1, 1'b0, 2);
        check_bit("reset_level", level, 1'b0);
        check_bit("reset_pulse", pulse, 1'b0);
        reset_n = 1'b1;
        hold(1'b1, 1'b0, 5);

        // Clean press without repeat.
        new_window();
        hold(1'b0, 1'b0, 40);
        check_int("clean_pulse_count", pulse_idx.size(), 1);
        check_pulse_at("clean_pulse_edge", 0, 6);
        check_bit("clean_level_held", level, 1'b1);
        hold(1'b1, 1'b0, 12);
        check_bit("clean_level_released", level, 1'b0);
        check_int("clean_no_release_pulse", pulse_idx.size(), 1);

        // Bounces shorter than the debounce window are rejected.
        new_window();
        hold(1'b0, 1'b0, 3);
        hold(1'b1, 1'b0, 2);
        hold(1'b0, 1'b0, 3);
        hold(1'b1, 1'b0, 10);
        check_int("bounce_pulse_count", pulse_idx.size(), 0);
        check_bit("bounce_level", level, 1'b0);

        // Auto-repeat.
        new_window();
        hold(1'b0, 1'b1, 32);
        check_int("repeat_pulse_count", pulse_idx.size(), 5);
        check_pulse_at("repeat_p0", 0, 6);
        check_pulse_at("repeat_p1", 1, 16);
        check_pulse_at("repeat_p2", 2, 21);
        check_pulse_at("repeat_p3", 3, 26);
        check_pulse_at("repeat_p4", 4, 31);
        hold(1'b1, 1'b1, 12);
        check_int("repeat_none_after_release", pulse_idx.size(), 5);

        // A release bounce restarts the hold timing.
        new_window();
        hold(1'b0, 1'b1, 8);
        hold(1'b1, 1'b1, 2);
        hold(1'b0, 1'b1, 20);
        check_pulse_at("relbounce_p0", 0, 6);
        check_pulse_at("relbounce_p1", 1, 22);
        check_bit("relbounce_level", level, 1'b1);
        hold(1'b1, 1'b1, 12);

        // Drop repeat_en while repeating, then re-enable it.
        new_window();
        hold(1'b0, 1'b1, 18);
        hold(1'b0, 1'b0, 12);
        check_int("repdrop_pulse_count", pulse_idx.size(), 2);
        check_bit("repdrop_level", level, 1'b1);
        hold(1'b0, 1'b1, 15);
        check_pulse_at("repdrop_resume", 2, 39);
        hold(1'b1, 1'b0, 12);

        // Asynchronous reset during repeat, with the button still held.
        hold(1'b0, 1'b1, 20);
        #2 reset_n = 1'b0;
        #1;
        check_bit("async_reset_level", level, 1'b0);
        check_bit("async_reset_pulse", pulse, 1'b0);
        model_reset();
        hold(1'b0, 1'b1, 3);
        reset_n = 1'b1;
        new_window();
        hold(1'b0, 1'b1, 10);
        check_pulse_at("post_reset_pulse", 0, 6);
        hold(1'b1, 1'b0, 12);

        // Random segments of button activity and repeat_en changes.
        begin
            logic rep_r;
            rep_r = 1'b0;
            for (int seg = 0; seg < 90; seg++) begin
                logic b;
                int len;
                b = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) len = int'($urandom_range(15, 45));
                else len = int'($urandom_range(1, 6));
                if ($urandom_range(0, 4) == 0) rep_r = ~rep_r;
                hold(b, rep_r, len);
            end
        end
        hold(1'b1, 1'b0, 12);
        check_bit("final_level", level, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
